// File: rtl/hash_table_requester_if.sv
// Host/command/response/result bundle for hash_table_requester.
// master = requester side, slave = host/table environment side.
interface hash_table_requester_if #(
   parameter int unsigned KEY_WIDTH  = 15,
   parameter int unsigned DATA_WIDTH = 15
);
   localparam int unsigned CMD_WIDTH = 2 + DATA_WIDTH + KEY_WIDTH;

   logic                  host_valid_i;
   logic                  host_ready_o;
   logic [1:0]            host_op_i;
   logic [KEY_WIDTH-1:0]  host_key_i;
   logic [DATA_WIDTH-1:0] host_data_i;

   logic                  cmd_valid_o;
   logic                  cmd_ready_i;
   logic [CMD_WIDTH-1:0]  cmd_data_o;

   logic                  rsp_valid_i;
   logic                  rsp_ready_o;
   logic [31:0]           rsp_data_i;

   logic                  res_valid_o;
   logic                  res_ready_i;
   logic [1:0]            res_op_o;
   logic [DATA_WIDTH-1:0] res_data_o;
   logic [2:0]            res_status_o;
   logic                  spurious_o;

   modport master (
      input  host_valid_i, host_op_i, host_key_i, host_data_i,
      output host_ready_o,
      output cmd_valid_o, cmd_data_o,
      input  cmd_ready_i,
      input  rsp_valid_i, rsp_data_i,
      output rsp_ready_o,
      output res_valid_o, res_op_o, res_data_o, res_status_o, spurious_o,
      input  res_ready_i
   );

   modport slave (
      output host_valid_i, host_op_i, host_key_i, host_data_i,
      input  host_ready_o,
      input  cmd_valid_o, cmd_data_o,
      output cmd_ready_i,
      output rsp_valid_i, rsp_data_i,
      input  rsp_ready_o,
      input  res_valid_o, res_op_o, res_data_o, res_status_o, spurious_o,
      output res_ready_i
   );
endinterface

// File: rtl/hash_table_requester.sv
// Hash-table initiator: packs host ops into commands, tracks outstanding ops, decodes responses.
// Optional macro HASH_REQ_PAD_CHECK_EN: non-all-ones response padding yields PROTOCOL_ERR.
module hash_table_requester #(
   parameter int unsigned KEY_WIDTH       = 15,
   parameter int unsigned DATA_WIDTH      = 15,  // must be <= 27
   parameter int unsigned MAX_OUTSTANDING = 4    // power of two, >= 2
) (
   input logic                  clk,
   input logic                  reset,
   hash_table_requester_if.master bus
);
   localparam int unsigned CMD_WIDTH = 2 + DATA_WIDTH + KEY_WIDTH;
   localparam int unsigned PTR_W     = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W     = PTR_W + 1;

   localparam logic [1:0] OP_NONE   = 2'b00;
   localparam logic [1:0] OP_READ   = 2'b01;
   localparam logic [1:0] OP_WRITE  = 2'b10;
   localparam logic [1:0] OP_DELETE = 2'b11;

   typedef enum logic [2:0] {
      ST_OK          = 3'd0,
      ST_NOT_FOUND   = 3'd1,
      ST_NO_SPACE    = 3'd2,
      ST_KEY_PRESENT = 3'd3,
      ST_NO_DEL      = 3'd4,
      ST_PROTO_ERR   = 3'd5
   } status_e;

   logic                  cmd_valid;
   logic [CMD_WIDTH-1:0]  cmd_data;
   logic [1:0]            op_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  res_valid;
   logic [1:0]            res_op;
   logic [DATA_WIDTH-1:0] res_data;
   logic [2:0]            res_status;
   logic                  spurious;

   logic                  host_ready, host_hs, cmd_hs;
   logic                  rsp_ready, rsp_hs, fifo_empty, pop;
   logic [1:0]            head_op;
   logic [3:0]            flags, allowed;
   status_e               dec_status;
   logic [DATA_WIDTH-1:0] dec_data;

   // A command sitting in the output register counts against the limit, so the
   // counter can never pass MAX_OUTSTANDING even when the table accepts immediately.
   assign host_ready = (!cmd_valid || bus.cmd_ready_i) &&
                       ((count + CNT_W'(cmd_valid)) < CNT_W'(MAX_OUTSTANDING));
   assign host_hs    = bus.host_valid_i && host_ready;
   assign cmd_hs     = cmd_valid && bus.cmd_ready_i;
   assign rsp_ready  = !res_valid || bus.res_ready_i;
   assign rsp_hs     = bus.rsp_valid_i && rsp_ready;
   assign fifo_empty = (count == '0);
   assign pop        = rsp_hs && !fifo_empty;
   assign head_op    = op_fifo[rd_ptr];
   assign flags      = bus.rsp_data_i[31:28];

   // Response decode against the op at the head of the FIFO
   always_comb begin
      dec_status = ST_OK;
      dec_data   = '0;
      case (head_op)
         OP_READ:   allowed = 4'b0100;
         OP_WRITE:  allowed = 4'b1010;
         OP_DELETE: allowed = 4'b0001;
         default:   allowed = 4'b0000;
      endcase
      if (((flags & ~allowed) != 4'b0000) || ($countones(flags) > 1)) dec_status = ST_PROTO_ERR;
      else if (flags[3])                                              dec_status = ST_KEY_PRESENT;
      else if (flags[2])                                              dec_status = ST_NOT_FOUND;
      else if (flags[1])                                              dec_status = ST_NO_SPACE;
      else if (flags[0])                                              dec_status = ST_NO_DEL;
`ifdef HASH_REQ_PAD_CHECK_EN
      if (!(&bus.rsp_data_i[27:DATA_WIDTH])) dec_status = ST_PROTO_ERR;
`endif
      if (head_op == OP_READ && dec_status == ST_OK) dec_data = bus.rsp_data_i[DATA_WIDTH-1:0];
   end

`ifndef HASH_REQ_PAD_CHECK_EN
   logic unused_pad;
   assign unused_pad = ^bus.rsp_data_i[27:DATA_WIDTH];
`endif

   // Command output register; reserved op is consumed without issuing anything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_valid <= 1'b0;
         cmd_data  <= '0;
      end else if (host_hs) begin
         cmd_valid <= (bus.host_op_i != OP_NONE);
         if (bus.host_op_i != OP_NONE)
            cmd_data <= {bus.host_op_i, bus.host_key_i, bus.host_data_i};
      end else if (cmd_hs) begin
         cmd_valid <= 1'b0;
      end
   end

   // In-order op FIFO and outstanding counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) op_fifo[i] <= OP_NONE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (cmd_hs) begin
            op_fifo[wr_ptr] <= cmd_data[CMD_WIDTH-1 -: 2];
            wr_ptr          <= PTR_W'(wr_ptr + 1'b1);
         end
         if (pop) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
         if (cmd_hs && !pop)      count <= CNT_W'(count + 1'b1);
         else if (!cmd_hs && pop) count <= CNT_W'(count - 1'b1);
      end
   end

   // Result register and sticky spurious-response flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid  <= 1'b0;
         res_op     <= '0;
         res_data   <= '0;
         res_status <= '0;
         spurious   <= 1'b0;
      end else begin
         if (pop) begin
            res_valid  <= 1'b1;
            res_op     <= head_op;
            res_data   <= dec_data;
            res_status <= dec_status;
         end else if (bus.res_ready_i) begin
            res_valid  <= 1'b0;
         end
         if (rsp_hs && fifo_empty) spurious <= 1'b1;
      end
   end

   assign bus.host_ready_o = host_ready;
   assign bus.cmd_valid_o  = cmd_valid;
   assign bus.cmd_data_o   = cmd_data;
   assign bus.rsp_ready_o  = rsp_ready;
   assign bus.res_valid_o  = res_valid;
   assign bus.res_op_o     = res_op;
   assign bus.res_data_o   = res_data;
   assign bus.res_status_o = res_status;
   assign bus.spurious_o   = spurious;
endmodule
